coef_updater: RTL and testbench
===============================

Name: coef_updater

Overview:
- Gradient-descent stage directly downstream of the error calculator in the linear-regression datapath.
- Consumes per-sample (x, e) pairs and accumulates sum(e) and sum(e·x) over one epoch.
- At epoch end, updates b0 and b1 with a shift-based learning rate.
- Updated b1/b0 feed back to the error calculator for the next epoch.

Parameters:
DATA_W, 20, signed fixed-point width of x, e, b0, b1
FRAC_W, 10, fractional bits (1.0 = 1024)
CNT_W, 8, sample counter width
LR_SHIFT, 4, learning rate = 2^-LR_SHIFT (arithmetic right shift)
ACC_W, 32, signed accumulator width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
load_init  in  1  load b0_init/b1_init into coefficients (IDLE only)
b0_init  in  DATA_W  initial intercept
b1_init  in  DATA_W  initial slope
start  in  1  begin epoch; sampled in IDLE only
n_samples  in  CNT_W  samples per epoch; latched at start
x_in  in  DATA_W  sample x
e_in  in  DATA_W  sample error (y − b1·x − b0)
e_valid  in  1  x_in/e_in valid
e_ready  out  1  accepting samples (high only in ACCUM)
b0_out  out  DATA_W  current intercept
b1_out  out  DATA_W  current slope
busy  out  1  high in ACCUM and UPDATE
update_done  out  1  one-cycle pulse after coefficients are written
epoch_cnt  out  CNT_W  completed epochs, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE; b0_out=b1_out=0, sum_e=sum_ex=0, sample count=0, epoch_cnt=0, e_ready=0, busy=0, update_done=0.
- rst=0 in any state, including mid-epoch, aborts the epoch with no coefficient update.
- States: IDLE, ACCUM, UPDATE, DONE.
- IDLE:
  - load_init=1 loads b0/b1 from the init ports.
  - start=1 latches n_samples, clears sums and count.
  - If start and load_init are both high, the load takes effect and start is also taken.
  - After start: next state ACCUM, or UPDATE if n_samples=0 (b unchanged, epoch_cnt still increments).
- ACCUM:
  - e_ready=1. A sample is accepted on the cycle where e_valid & e_ready.
  - On accept: sum_e += sext(e_in); sum_ex += (x_in·e_in) >>> FRAC_W, computed from the full 2·DATA_W signed product; count += 1.
  - The cycle that accepts sample number n_samples moves to UPDATE; e_ready=0 from the next cycle.
  - e_valid=0 stalls indefinitely with no state change.
- UPDATE (exactly 1 cycle): b0 ← b0 + (sum_e >>> LR_SHIFT); b1 ← b1 + (sum_ex >>> LR_SHIFT). Next state DONE.
- DONE (1 cycle): update_done=1, epoch_cnt += 1, then IDLE.
- start/load_init outside IDLE are ignored.
- Latency: the last accepted sample's edge is followed by b_out changing at the next edge; update_done is high during the cycle after that.
- Width rules:
  - Accumulators are ACC_W signed.
  - Update addend is truncated to DATA_W after the shift.
  - Overflow handling is set by the optional feature.
- b0_out/b1_out are registered and stable outside the UPDATE edge.

Optional Feature:
- Macro COEF_UPD_SAT_EN.
- Defined:
  - Accumulator adds saturate at ±(2^(ACC_W−1)) bounds.
  - Coefficient adds and the addend truncation clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Undefined: all adds wrap two's-complement, with no clamp logic.

Test Plan:
1. Reset, load_init with b0_init=0, b1_init=0; start n=2; samples (x=1024, e=512) twice → b0_out=64, b1_out=64, update_done pulse, epoch_cnt=1.
2. Start n=0 → no e_ready assertion, b unchanged, update_done after 3 cycles, epoch_cnt increments.
3. n=3 with e_valid deasserted 5 cycles between samples, x=−2048, e=256 → sum_e=768, sum_ex=−1536; b0 += 48, b1 += −96.
4. rst=0 asserted after 1 of 4 samples → IDLE, b0/b1=0, no update_done; start/load_init while busy → ignored.
5. With COEF_UPD_SAT_EN: b1_init=524287, samples giving positive addend 64 → b1_out=524287. Without the macro, the same stimulus → b1_out wraps to −524225.
6. 256 epochs of n=1, e=0 → epoch_cnt wraps to 0, coefficients unchanged.

Source files
------------

// File: rtl/coef_updater.sv
// Gradient-descent coefficient updater: accumulates sum(e) and sum(e*x) per epoch, then nudges b0/b1.
// Optional macro COEF_UPD_SAT_EN: saturating accumulators and clamped coefficient updates (default wraps).
module coef_updater #(
    parameter int DATA_W   = 20,
    parameter int FRAC_W   = 10,
    parameter int CNT_W    = 8,
    parameter int LR_SHIFT = 4,
    parameter int ACC_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_init,
    input  logic signed [DATA_W-1:0] b0_init,
    input  logic signed [DATA_W-1:0] b1_init,
    input  logic                     start,
    input  logic        [CNT_W-1:0]  n_samples,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] e_in,
    input  logic                     e_valid,
    output logic                     e_ready,
    output logic signed [DATA_W-1:0] b0_out,
    output logic signed [DATA_W-1:0] b1_out,
    output logic                     busy,
    output logic                     update_done,
    output logic        [CNT_W-1:0]  epoch_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

`ifdef COEF_UPD_SAT_EN
    localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  D_MAX_A  = ACC_W'(DATA_MAX);
    localparam logic signed [ACC_W-1:0]  D_MIN_A  = ACC_W'(DATA_MIN);
`endif

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
`ifdef COEF_UPD_SAT_EN
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] to_data(input logic signed [ACC_W-1:0] v);
`ifdef COEF_UPD_SAT_EN
        if (v > D_MAX_A) return DATA_MAX;
        if (v < D_MIN_A) return DATA_MIN;
`endif
        return DATA_W'(v);
    endfunction

    function automatic logic signed [DATA_W-1:0] coef_add(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
`ifdef COEF_UPD_SAT_EN
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? DATA_MIN : DATA_MAX;
        return s[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    state_t                     state_q;
    logic signed [DATA_W-1:0]   b0_q, b1_q;
    logic signed [ACC_W-1:0]    sum_e_q, sum_ex_q;
    logic        [CNT_W-1:0]    cnt_q, n_q, epoch_q;
    logic                       e_ready_q, busy_q, done_q;

    logic signed [ACC_W-1:0]    e_ext, prod_acc, sum_e_d, sum_ex_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   b0_d, b1_d;
    logic        [CNT_W-1:0]    cnt_d;

    // Product keeps full precision; only the rescaled value is narrowed to the accumulator.
    always_comb begin
        e_ext    = ACC_W'(e_in);
        prod     = x_in * e_in;
        prod_acc = ACC_W'(prod >>> FRAC_W);
        sum_e_d  = acc_add(sum_e_q, e_ext);
        sum_ex_d = acc_add(sum_ex_q, prod_acc);
        cnt_d    = cnt_q + CNT_W'(1);
        b0_d     = coef_add(b0_q, to_data(sum_e_q  >>> LR_SHIFT));
        b1_d     = coef_add(b1_q, to_data(sum_ex_q >>> LR_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            b0_q      <= '0;
            b1_q      <= '0;
            sum_e_q   <= '0;
            sum_ex_q  <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            epoch_q   <= '0;
            e_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load_init) begin
                        b0_q <= b0_init;
                        b1_q <= b1_init;
                    end
                    if (start) begin
                        n_q      <= n_samples;
                        sum_e_q  <= '0;
                        sum_ex_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (n_samples == '0) begin
                            state_q   <= UPDATE;
                            e_ready_q <= 1'b0;
                        end else begin
                            state_q   <= ACCUM;
                            e_ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (e_valid && e_ready_q) begin
                        sum_e_q  <= sum_e_d;
                        sum_ex_q <= sum_ex_d;
                        cnt_q    <= cnt_d;
                        if (cnt_d == n_q) begin
                            state_q   <= UPDATE;
                            e_ready_q <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    b0_q    <= b0_d;
                    b1_q    <= b1_d;
                    epoch_q <= epoch_q + CNT_W'(1);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign e_ready     = e_ready_q;
    assign busy        = busy_q;
    assign update_done = done_q;
    assign b0_out      = b0_q;
    assign b1_out      = b1_q;
    assign epoch_cnt   = epoch_q;

endmodule

// File: tb/tb_coef_updater.sv
// Directed bench for coef_updater with a scoreboard of expected coefficients per epoch.
module tb_coef_updater;
    localparam int DATA_W = 20;
    localparam int CNT_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     load_init = 1'b0;
    logic signed [DATA_W-1:0] b0_init = '0, b1_init = '0;
    logic                     start = 1'b0;
    logic        [CNT_W-1:0]  n_samples = '0;
    logic signed [DATA_W-1:0] x_in = '0, e_in = '0;
    logic                     e_valid = 1'b0;
    logic                     e_ready, busy, update_done;
    logic signed [DATA_W-1:0] b0_out, b1_out;
    logic        [CNT_W-1:0]  epoch_cnt;

    coef_updater dut (
        .clk(clk), .rst(rst), .load_init(load_init), .b0_init(b0_init), .b1_init(b1_init),
        .start(start), .n_samples(n_samples), .x_in(x_in), .e_in(e_in), .e_valid(e_valid),
        .e_ready(e_ready), .b0_out(b0_out), .b1_out(b1_out), .busy(busy),
        .update_done(update_done), .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint b0;
        longint b1;
        longint ep;
    } exp_t;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    longint m_b0 = 0, m_b1 = 0, m_ep = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on wide integers, narrowed explicitly.
    function automatic longint acc_fix(input longint s);
`ifdef COEF_UPD_SAT_EN
        if (s > 64'sd2147483647)  return 64'sd2147483647;
        if (s < -64'sd2147483648) return -64'sd2147483648;
        return s;
`else
        int t;
        t = int'(s);
        return longint'(t);
`endif
    endfunction

    function automatic longint data_fix(input longint s);
`ifdef COEF_UPD_SAT_EN
        if (s > 64'sd524287)  return 64'sd524287;
        if (s < -64'sd524288) return -64'sd524288;
        return s;
`else
        logic signed [19:0] t;
        t = s[19:0];
        return longint'(t);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_b0 = 0; m_b1 = 0; m_ep = 0;
        sb_q.delete();
    endtask

    task automatic do_load(input longint b0, input longint b1);
        load_init = 1'b1;
        b0_init = DATA_W'(b0);
        b1_init = DATA_W'(b1);
        tick();
        load_init = 1'b0;
        m_b0 = b0; m_b1 = b1;
    endtask

    task automatic wait_done();
        int   k;
        exp_t ex;
        k = 0;
        while (!update_done && k < 10) begin
            tick();
            k++;
        end
        chk("done_latency", k, 1);
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            chk("b0_out", b0_out, ex.b0);
            chk("b1_out", b1_out, ex.b1);
            chk("epoch_cnt", epoch_cnt, ex.ep);
            $display("epoch %0d: b0=%0d b1=%0d epoch_cnt=%0d", ex.ep, b0_out, b1_out, epoch_cnt);
        end
        tick();
        chk("done_pulse_end", update_done, 0);
        chk("busy_after", busy, 0);
    endtask

    // n identical samples (x, e), with 'gap' idle cycles between samples.
    task automatic run_epoch(input int n, input longint x, input longint e, input int gap);
        longint se, sex, p;
        longint old_b0, old_b1;
        exp_t   ex;
        int     k;
        se = 0; sex = 0;
        for (int i = 0; i < n; i++) begin
            p   = (x * e) >>> 10;
            se  = acc_fix(se + e);
            sex = acc_fix(sex + acc_fix(p));
        end
        old_b0 = m_b0; old_b1 = m_b1;
        m_b0 = data_fix(m_b0 + data_fix(se  >>> 4));
        m_b1 = data_fix(m_b1 + data_fix(sex >>> 4));
        m_ep = (m_ep + 1) % 256;
        ex.b0 = m_b0; ex.b1 = m_b1; ex.ep = m_ep;
        sb_q.push_back(ex);

        start = 1'b1;
        n_samples = CNT_W'(n);
        tick();
        start = 1'b0;
        chk("busy_start", busy, 1);
        chk("e_ready_start", e_ready, (n != 0));
        for (int i = 0; i < n; i++) begin
            x_in = DATA_W'(x);
            e_in = DATA_W'(e);
            e_valid = 1'b1;
            k = 0;
            while (!e_ready && k < 20) begin
                tick();
                k++;
            end
            chk("e_ready_wait", e_ready, 1);
            tick();
            e_valid = 1'b0;
            if (i < n - 1) begin
                repeat (gap) tick();
                if (gap > 0) chk("stall_ready", e_ready, 1);
            end
        end
        chk("b0_hold_pre", b0_out, old_b0);
        chk("b1_hold_pre", b1_out, old_b1);
        wait_done();
    endtask

    initial begin
        int seen_done;
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_b0", b0_out, 0);
        chk("rst_b1", b1_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", e_ready, 0);
        chk("rst_done", update_done, 0);
        chk("rst_epoch", epoch_cnt, 0);
        rst = 1'b1;

        // 1: basic epoch
        do_load(0, 0);
        run_epoch(2, 1024, 512, 0);
        chk("t1_b0", b0_out, 64);
        chk("t1_b1", b1_out, 64);

        // 2: empty epoch
        run_epoch(0, 0, 0, 0);
        chk("t2_b0", b0_out, 64);
        chk("t2_epoch", epoch_cnt, 2);

        // 3: stalled samples, negative x
        run_epoch(3, -2048, 256, 5);
        chk("t3_b0", b0_out, 112);
        chk("t3_b1", b1_out, -32);

        // 4: mid-epoch reset; start/load_init ignored while busy
        start = 1'b1;
        n_samples = 8'd4;
        tick();
        start = 1'b0;
        x_in = 20'sd1024; e_in = 20'sd1024; e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
        load_init = 1'b1; b0_init = 20'sd999; b1_init = 20'sd999; start = 1'b1;
        tick();
        load_init = 1'b0; start = 1'b0;
        chk("t4_ignore_b0", b0_out, 112);
        chk("t4_ignore_b1", b1_out, -32);
        chk("t4_busy", busy, 1);
        chk("t4_ready", e_ready, 1);
        do_reset();
        chk("t4_b0", b0_out, 0);
        chk("t4_b1", b1_out, 0);
        chk("t4_busy_rst", busy, 0);
        chk("t4_ready_rst", e_ready, 0);
        chk("t4_epoch", epoch_cnt, 0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (update_done) seen_done = 1;
            tick();
        end
        chk("t4_no_done", seen_done, 0);

        // 5: overflow at the top of b1
        do_load(0, 524287);
        run_epoch(1, 1024, 1024, 0);
`ifdef COEF_UPD_SAT_EN
        chk("t5_b1", b1_out, 524287);
`else
        chk("t5_b1", b1_out, -524225);
`endif

        // 6: epoch counter wrap
        do_reset();
        do_load(100, -200);
        for (int i = 0; i < 256; i++) run_epoch(1, 5, 0, 0);
        chk("t6_epoch_wrap", epoch_cnt, 0);
        chk("t6_b0", b0_out, 100);
        chk("t6_b1", b1_out, -200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
